// File: rtl/loop_sequencer.sv
// loop_sequencer: two-level loop controller. An inner down counter runs from
// INNER_INIT to 0 once per outer pass; an outer down counter runs from
// OUTER_INIT to 0. One step strobe is issued per iteration. A step advances
// only when the datapath accepts it (step & ready). Completion is signalled by
// a one-cycle done pulse.
module loop_sequencer #(
   parameter int INNER_W    = 3,
   parameter int OUTER_W    = 4,
   parameter int INNER_INIT = 7,
   parameter int OUTER_INIT = 15
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               abort,
   input  logic               ready,
   output logic               step,
   output logic [INNER_W-1:0] inner_idx,
   output logic [OUTER_W-1:0] outer_idx,
   output logic               inner_last,
   output logic               busy,
   output logic               done
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_DONE
   } state_t;

   localparam logic [INNER_W-1:0] INNER_LOAD = INNER_W'(INNER_INIT);
   localparam logic [OUTER_W-1:0] OUTER_LOAD = OUTER_W'(OUTER_INIT);

   state_t             state, state_nxt;
   logic [INNER_W-1:0] inner_nxt;
   logic [OUTER_W-1:0] outer_nxt;

   // Next-state and next-index logic; abort overrides every other transition.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      state_nxt = state;
      inner_nxt = inner_idx;
      outer_nxt = outer_idx;
      case (state)
         S_IDLE: begin
            if (start && !abort) state_nxt = S_LOAD;
         end
         S_LOAD: begin
            if (abort) begin
               state_nxt = S_IDLE;
            end else begin
               inner_nxt = INNER_LOAD;
               outer_nxt = OUTER_LOAD;
               state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (abort) begin
               state_nxt = S_IDLE;
            end else if (ready) begin
               if (inner_idx != '0) begin
                  inner_nxt = inner_idx - 1'b1;
               end else if (outer_idx != '0) begin
                  inner_nxt = INNER_LOAD;
                  outer_nxt = outer_idx - 1'b1;
               end else begin
                  // Final step accepted; indices stay at zero.
                  state_nxt = S_DONE;
               end
            end
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // State and index registers with asynchronous active-low clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         inner_idx <= '0;
         outer_idx <= '0;
      end else begin
         // NOTE: non-blocking assignments so all registers update from the same pre-edge values.
         state     <= state_nxt;
         inner_idx <= inner_nxt;
         outer_idx <= outer_nxt;
      end
   end

   // Outputs are pure decodes of registered state; none depends on ready.
   assign step       = (state == S_RUN);
   assign busy       = (state == S_LOAD) || (state == S_RUN);
   assign done       = (state == S_DONE);
   assign inner_last = step && (inner_idx == '0);

endmodule

// File: tb/tb_loop_sequencer.sv
// tb_loop_sequencer: drives three loop_sequencer instances (2/1, 7/15 and the
// degenerate 0/0 configuration) from shared inputs and compares every cycle
// against a reference model that derives indices from the count of accepted
// steps. Directed scenarios cover the worked 6-step example, back-pressure,
// start during RUN, abort, async reset, followed by a randomized phase.
module tb_loop_sequencer;

   localparam int N = 3;
   localparam int II [N] = '{2, 7, 0};
   localparam int OI [N] = '{1, 15, 0};

   localparam int P_IDLE = 0;
   localparam int P_LOAD = 1;
   localparam int P_RUN  = 2;
   localparam int P_DONE = 3;

   logic clk = 1'b0;
   logic rst, start, abort, ready;

   logic       step_s       [N];
   logic [2:0] in_s         [N];
   logic [3:0] out_s        [N];
   logic       inner_last_s [N];
   logic       busy_s       [N];
   logic       done_s       [N];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // reference model: phase, accepted-step count, expected indices
   int ph [N];
   int k  [N];
   int mi [N];
   int mo [N];

   // latency bookkeeping from observed outputs
   logic obs_step   [N];
   logic run_active [N];
   int   first_cyc  [N];
   int   acc        [N];
   int   stall      [N];
   int   last_lat   [N];

   // directed sequence tracking for the 2/1 instance
   logic track_a = 1'b0;
   int   seq_n   = 0;
   int   exp_o [6] = '{1, 1, 1, 0, 0, 0};
   int   exp_i [6] = '{2, 1, 0, 2, 1, 0};

   loop_sequencer #(.INNER_W(3), .OUTER_W(4), .INNER_INIT(2), .OUTER_INIT(1)) dut_a (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .ready(ready),
      .step(step_s[0]), .inner_idx(in_s[0]), .outer_idx(out_s[0]),
      .inner_last(inner_last_s[0]), .busy(busy_s[0]), .done(done_s[0]));

   loop_sequencer #(.INNER_W(3), .OUTER_W(4), .INNER_INIT(7), .OUTER_INIT(15)) dut_b (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .ready(ready),
      .step(step_s[1]), .inner_idx(in_s[1]), .outer_idx(out_s[1]),
      .inner_last(inner_last_s[1]), .busy(busy_s[1]), .done(done_s[1]));

   loop_sequencer #(.INNER_W(3), .OUTER_W(4), .INNER_INIT(0), .OUTER_INIT(0)) dut_c (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .ready(ready),
      .step(step_s[2]), .inner_idx(in_s[2]), .outer_idx(out_s[2]),
      .inner_last(inner_last_s[2]), .busy(busy_s[2]), .done(done_s[2]));

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int total(input int j);
      return (II[j] + 1) * (OI[j] + 1);
   endfunction

   // indices follow from how many steps remain in the flattened loop
   task automatic set_idx(input int j);
      int rem;
      rem   = total(j) - 1 - k[j];
      mo[j] = rem / (II[j] + 1);
      mi[j] = rem % (II[j] + 1);
   endtask

   task automatic model_reset();
      for (int j = 0; j < N; j++) begin
         ph[j] = P_IDLE; k[j] = 0; mi[j] = 0; mo[j] = 0;
         obs_step[j] = 1'b0; run_active[j] = 1'b0;
         first_cyc[j] = 0; acc[j] = 0; stall[j] = 0;
      end
   endtask

   task automatic model_update(input int j);
      case (ph[j])
         P_IDLE: if (start && !abort) ph[j] = P_LOAD;
         P_LOAD: begin
            if (abort) ph[j] = P_IDLE;
            else begin k[j] = 0; set_idx(j); ph[j] = P_RUN; end
         end
         P_RUN: begin
            if (abort) ph[j] = P_IDLE;
            else if (ready) begin
               if (k[j] == total(j) - 1) ph[j] = P_DONE;
               else begin k[j]++; set_idx(j); end
            end
         end
         default: ph[j] = P_IDLE;
      endcase
   endtask

   task automatic check_outputs(input int j);
      logic es;
      es = (ph[j] == P_RUN);
      check($sformatf("u%0d step", j), step_s[j], es);
      check($sformatf("u%0d busy", j), busy_s[j], (ph[j] == P_LOAD) || es);
      check($sformatf("u%0d done", j), done_s[j], ph[j] == P_DONE);
      check($sformatf("u%0d inner_idx", j), in_s[j], mi[j]);
      check($sformatf("u%0d outer_idx", j), out_s[j], mo[j]);
      check($sformatf("u%0d inner_last", j), inner_last_s[j], es && (mi[j] == 0));
   endtask

   task automatic tick();
      @(posedge clk);
      for (int j = 0; j < N; j++) begin
         if (obs_step[j]) begin
            if (!run_active[j]) begin
               run_active[j] = 1'b1; first_cyc[j] = cyc; acc[j] = 0; stall[j] = 0;
            end
            if (ready) acc[j]++;
            else stall[j]++;
         end
      end
      cyc++;
      for (int j = 0; j < N; j++) model_update(j);
      #1;
      for (int j = 0; j < N; j++) begin
         check_outputs(j);
         obs_step[j] = step_s[j];
         if (done_s[j]) begin
            if (run_active[j]) begin
               check($sformatf("u%0d accepted steps", j), acc[j], total(j));
               check($sformatf("u%0d done latency", j), cyc - first_cyc[j], total(j) + stall[j]);
               last_lat[j] = cyc - first_cyc[j];
            end
            run_active[j] = 1'b0;
         end else if (!busy_s[j]) begin
            run_active[j] = 1'b0;
         end
      end
      if (track_a && step_s[0]) begin
         if (seq_n < 6) begin
            check($sformatf("seq outer step%0d", seq_n), out_s[0], exp_o[seq_n]);
            check($sformatf("seq inner step%0d", seq_n), in_s[0], exp_i[seq_n]);
            check($sformatf("seq inner_last step%0d", seq_n), inner_last_s[0], (seq_n == 2) || (seq_n == 5));
         end
         seq_n++;
      end
   endtask

   task automatic run_until_idle(input int budget, input string tag);
      int n;
      logic any;
      n = 0;
      do begin
         tick();
         n++;
         any = 1'b0;
         for (int j = 0; j < N; j++) if (ph[j] != P_IDLE) any = 1'b1;
      end while (any && n < budget);
      check($sformatf("%s finished within budget", tag), n < budget, 1'b1);
   endtask

   task automatic check_zero(input string tag);
      for (int j = 0; j < N; j++) begin
         check($sformatf("%s u%0d step", tag, j), step_s[j], 1'b0);
         check($sformatf("%s u%0d busy", tag, j), busy_s[j], 1'b0);
         check($sformatf("%s u%0d done", tag, j), done_s[j], 1'b0);
         check($sformatf("%s u%0d inner_last", tag, j), inner_last_s[j], 1'b0);
         check($sformatf("%s u%0d inner_idx", tag, j), in_s[j], 0);
         check($sformatf("%s u%0d outer_idx", tag, j), out_s[j], 0);
      end
   endtask

   initial begin
      // 1. reset
      rst = 1'b0; start = 1'b0; abort = 1'b0; ready = 1'b1;
      model_reset();
      #3;
      check_zero("reset");
      @(negedge clk);
      rst = 1'b1;
      tick();
      tick();

      // 2 + 4. worked example on 2/1, full 128-step run on 7/15, single step on 0/0
      track_a = 1'b1; seq_n = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int t = 0; t < 10; t++) tick();
      track_a = 1'b0;
      check("seq step count", seq_n, 6);
      check("u0 latency example", last_lat[0], 6);
      check("u2 latency single step", last_lat[2], 1);
      for (int t = 0; t < 10; t++) tick();
      start = 1'b1;          // u1 is in RUN here and must ignore it
      tick();
      start = 1'b0;
      run_until_idle(400, "default run");
      check("u1 latency 128", last_lat[1], 128);

      // 3. back-pressure: three stalled cycles at (1,1)
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      ready = 1'b0;
      for (int t = 0; t < 3; t++) tick();
      check("stall outer held", out_s[0], 1);
      check("stall inner held", in_s[0], 1);
      ready = 1'b1;
      run_until_idle(400, "stall run");
      check("u0 latency with stall", last_lat[0], 9);

      // 5. abort the 7/15 instance at (0,1) under random back-pressure
      start = 1'b1;
      tick();
      start = 1'b0;
      begin
         int n;
         n = 0;
         while (!(ph[1] == P_RUN && mo[1] == 0 && mi[1] == 1) && n < 1000) begin
            ready = ($urandom_range(0, 3) != 0);
            tick();
            n++;
         end
         check("reach (0,1) within budget", n < 1000, 1'b1);
      end
      abort = 1'b1; ready = 1'b1;
      tick();
      abort = 1'b0;
      check("abort busy", busy_s[1], 1'b0);
      check("abort done", done_s[1], 1'b0);
      check("abort inner held", in_s[1], 1);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      check("restart step", step_s[1], 1'b1);
      check("restart outer", out_s[1], 15);
      check("restart inner", in_s[1], 7);
      run_until_idle(400, "post-abort run");

      // randomized start/abort/ready
      for (int t = 0; t < 600; t++) begin
         start = ($urandom_range(0, 7) == 0);
         abort = ($urandom_range(0, 47) == 0);
         ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      start = 1'b0; abort = 1'b0; ready = 1'b1;
      run_until_idle(400, "random drain");

      // 6. async reset during RUN
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int t = 0; t < 10; t++) tick();
      #2;
      rst = 1'b0;
      #1;
      check_zero("mid-run reset");
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      for (int t = 0; t < 4; t++) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      run_until_idle(400, "post-reset run");
      check("post-reset u1 latency", last_lat[1], 128);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
